cram_loader: RTL
================

CRAM_LOADER -- requirements
Module: cram_loader

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: cmd_valid  in  1  console command strobe.
REQ-004 SHALL have: cmd_ready  out  1  high when a command can be accepted.
REQ-005 SHALL have: cmd_op  in  3  0=LOAD_ADR, 1=LOAD_CHUNK, 2=WRITE, 3=READ, 4=READ_CHUNK, 5-7 illegal.
REQ-006 SHALL have: cmd_data  in  12  command operand.
REQ-007 SHALL have: rsp_valid  out  1  one-cycle readback strobe.
REQ-008 SHALL have: rsp_data  out  12  readback chunk.
REQ-009 SHALL have: cram_addr  out  11  CRAM word address (2048 words).
REQ-010 SHALL have: cram_din  out  84  write data, bit 0 = MSB (PDP-10 numbering [0:83]).
REQ-011 SHALL have: cram_wea  out  1  CRAM write enable.
REQ-012 SHALL have: cram_dout  in  84  CRAM read data, valid one cycle after cram_addr presented.
REQ-013 SHALL have: err  out  1  sticky illegal-command flag.

Function
REQ-014 A command SHALL be accepted only in a cycle with cmd_valid && cmd_ready.
REQ-015 States SHALL be IDLE, WR, RD1, RD2; cmd_ready SHALL equal (state==IDLE).
REQ-016 Chunk k (0..6) SHALL map to word bits [12k : 12k+11]; chunk 0 = bits 0:11, chunk 6 = bits 72:83.
REQ-017 LOAD_ADR: addr <= cmd_data[10:0] (bit 11 ignored); write pointer wptr <= 0; state stays IDLE.
REQ-018 LOAD_CHUNK: wbuf chunk[wptr] <= cmd_data; wptr increments, 6 wraps to 0.
REQ-019 WRITE: IDLE->WR; during WR cram_wea=1 for exactly one cycle with cram_addr=addr, cram_din=wbuf.
REQ-020 WR->IDLE next cycle: addr <= addr+1 modulo 2048 (2047 wraps to 0); wptr <= 0; wbuf retained.
REQ-021 READ: IDLE->RD1 (cram_addr=addr, cram_wea=0) -> RD2: rbuf <= cram_dout, rptr <= 0, addr <= addr+1 mod 2048 -> IDLE.
REQ-022 READ_CHUNK: following cycle rsp_valid=1 with rsp_data = rbuf chunk[rptr]; rptr increments, 6 wraps to 0; state stays IDLE.
REQ-023 rsp_valid SHALL be 0 in every cycle not specified by REQ-022.
REQ-024 Illegal op (5-7): no state, address, or buffer change; err <= 1 and held until rst.
REQ-025 cram_wea SHALL be 0 whenever state!=WR or rst=1 (no CRAM write in a reset cycle).
REQ-026 cram_addr SHALL always drive the internal addr register; cram_din SHALL always drive wbuf.
REQ-027 Back-to-back accepted IDLE commands SHALL be processed one per cycle with no loss.

Reset
REQ-028 On rst: state=IDLE, addr=0, wptr=0, rptr=0, wbuf=0, rbuf=0, err=0, rsp_valid=0, cram_wea=0, cmd_ready=1 next cycle.
REQ-029 rst in WR/RD1/RD2 SHALL abort the operation: no write, no address increment, no rbuf update.

Verification
REQ-030 LOAD_ADR 0x005, 7 LOAD_CHUNK 0x001..0x007, WRITE -> one cram_wea pulse at addr 5, cram_din = 0x001002003004005006007; addr becomes 6.
REQ-031 LOAD_ADR 0x7FF, WRITE, READ -> write at 2047, read at 0 (wrap), final addr=1.
REQ-032 Memory word 0xABC...(84-bit pattern) at addr 3; LOAD_ADR 3, READ, 8 READ_CHUNK -> rsp chunks 0..6 then chunk 0 again (rptr wrap); 8 rsp_valid pulses.
REQ-033 cmd_op=6 in IDLE -> err=1, addr/wptr unchanged, no rsp_valid, no cram_wea; err persists until rst.
REQ-034 rst asserted in WR cycle -> cram_wea=0 that cycle, addr=0 afterwards, cmd_ready=1 next cycle.
REQ-035 cmd_valid held high through WRITE -> cmd_ready=0 in WR; queued command accepted in the first cycle after return to IDLE.

Source files
------------

// File: rtl/cram_loader.sv
// Console loader for the 2048 x 84 control RAM: assembles words from seven
// 12-bit chunks for writing, and returns read words back one chunk at a time.
module cram_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [11:0] cmd_data,
    output logic        rsp_valid,
    output logic [11:0] rsp_data,
    output logic [10:0] cram_addr,
    output logic [83:0] cram_din,
    output logic        cram_wea,
    input  logic [83:0] cram_dout,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD1  = 2'd2;
    localparam logic [1:0] S_RD2  = 2'd3;

    localparam logic [2:0] OP_LOAD_ADR   = 3'd0;
    localparam logic [2:0] OP_LOAD_CHUNK = 3'd1;
    localparam logic [2:0] OP_WRITE      = 3'd2;
    localparam logic [2:0] OP_READ       = 3'd3;
    localparam logic [2:0] OP_READ_CHUNK = 3'd4;

    logic [1:0]  state;
    logic [10:0] addr;
    logic [2:0]  wptr;
    logic [2:0]  rptr;
    logic [83:0] wbuf;
    logic [83:0] rbuf;

    // PDP-10 bit n of a word sits at vector bit 83-n, so chunk 0 is the top 12 bits.
    function automatic logic [83:0] put_chunk(input logic [83:0] word, input logic [2:0] k,
                                              input logic [11:0] val);
        logic [83:0] res;
        res = word;
        case (k)
            3'd0:    res[83:72] = val;
            3'd1:    res[71:60] = val;
            3'd2:    res[59:48] = val;
            3'd3:    res[47:36] = val;
            3'd4:    res[35:24] = val;
            3'd5:    res[23:12] = val;
            3'd6:    res[11:0]  = val;
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [11:0] get_chunk(input logic [83:0] word, input logic [2:0] k);
        logic [11:0] res;
        case (k)
            3'd0:    res = word[83:72];
            3'd1:    res = word[71:60];
            3'd2:    res = word[59:48];
            3'd3:    res = word[47:36];
            3'd4:    res = word[35:24];
            3'd5:    res = word[23:12];
            3'd6:    res = word[11:0];
            default: res = 12'd0;
        endcase
        return res;
    endfunction

    function automatic logic [2:0] next_ptr(input logic [2:0] p);
        return (p == 3'd6) ? 3'd0 : p + 3'd1;
    endfunction

    assign cmd_ready = (state == S_IDLE);
    assign cram_addr = addr;
    assign cram_din  = wbuf;
    assign cram_wea  = (state == S_WR) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= 11'd0;
            wptr      <= 3'd0;
            rptr      <= 3'd0;
            wbuf      <= 84'd0;
            rbuf      <= 84'd0;
            err       <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_LOAD_ADR: begin
                                addr <= cmd_data[10:0];
                                wptr <= 3'd0;
                            end
                            OP_LOAD_CHUNK: begin
                                wbuf <= put_chunk(wbuf, wptr, cmd_data);
                                wptr <= next_ptr(wptr);
                            end
                            OP_WRITE:      state <= S_WR;
                            OP_READ:       state <= S_RD1;
                            OP_READ_CHUNK: begin
                                rsp_valid <= 1'b1;
                                rptr      <= next_ptr(rptr);
                            end
                            default:       err <= 1'b1;
                        endcase
                    end
                end
                S_WR: begin
                    addr  <= addr + 11'd1;
                    wptr  <= 3'd0;
                    state <= S_IDLE;
                end
                S_RD1: state <= S_RD2;
                default: begin
                    // cram_dout reflects the address presented during RD1.
                    rbuf  <= cram_dout;
                    rptr  <= 3'd0;
                    addr  <= addr + 11'd1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Readback data needs no reset; it is qualified by rsp_valid.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && cmd_valid && cmd_op == OP_READ_CHUNK)
            rsp_data <= get_chunk(rbuf, rptr);
    end

endmodule
